rule30_stream_checker: RTL and testbench
========================================

// Module: rule30_stream_checker
// PURPOSE
//  Receive-side checker for the Rule 30 PRNG word stream. Acquires lock on an
//  incoming N-bit stream by predicting each word from the previous one with the
//  Rule 30 update. Once locked, it counts mismatching words and drops lock after
//  repeated misses. Sits at the sink of a PRNG link or BIST path as a pass/fail monitor.
// PARAMETERS
//  N         32  word width; must match the generator width, >= 3
//  LOCK_CNT  4   consecutive matching words needed to enter LOCK, >= 1
//  LOSS_CNT  3   consecutive mismatching words in LOCK that force re-acquire, >= 1
//  CW        16  width of the error counters
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  data_in        in   N   received PRNG word
//  data_valid     in   1   data_in is sampled on a rising clk edge when high
//  clear          in   1   synchronous clear: counters to 0, state to IDLE
//  locked         out  1   high while state == LOCK (registered)
//  err_pulse      out  1   one-cycle pulse for each mismatching word seen in LOCK
//  err_count      out  CW  saturating count of mismatching words seen in LOCK
//  bit_err_count  out  CW  saturating count of mismatching bits (see CONFIGURATION)
// BEHAVIOUR
//  - Prediction: exp[i] = ref[(i+1)%N] ^ (ref[i] | ref[(i+N-1)%N]), where ref is
//    the internal N-bit reference word. match = (data_in == exp) && (data_in != 0).
//    An all-zero word never matches, because zero is a Rule 30 fixed point.
//  - Reset: state=IDLE; ref, run_cnt, miss_cnt = 0; all outputs = 0.
//  - Priority: reset > clear > data_valid. clear clears both counters and
//    run_cnt/miss_cnt, returns to IDLE, and ignores data_valid in the same cycle.
//  - data_valid low: no state, reference or counter change; err_pulse = 0.
//  - IDLE, on a valid word: ref <= data_in, run_cnt <= 0, go to ACQ.
//  - ACQ, on a valid word: ref <= data_in in all cases (self-synchronising).
//      match:    run_cnt++; on the LOCK_CNT-th match go to LOCK and set miss_cnt <= 0.
//      mismatch: run_cnt <= 0.
//    No errors are counted in ACQ.
//  - LOCK, on a valid word:
//      match:    ref <= data_in, miss_cnt <= 0.
//      mismatch: err_pulse=1 next cycle, err_count += 1, miss_cnt++, and
//                ref <= exp (flywheel: keep the predicted sequence). On the
//                LOSS_CNT-th consecutive miss: go to ACQ, ref <= data_in, run_cnt <= 0.
//  - Latency: locked rises on the clock edge that samples the LOCK_CNT-th
//    matching word, so it is visible in the following cycle. err_pulse and the
//    counter update are also visible the cycle after the bad word.
//  - Counters saturate at 2**CW-1 and do not wrap. Loss of lock does not clear them.
//  - Back-to-back valid words every cycle are supported at full rate.
// CONFIGURATION
//  RULE30_CHK_BITERR_EN defined: on each LOCK mismatch,
//    bit_err_count += popcount(data_in ^ exp), saturating at 2**CW-1.
//    Cleared by reset and by clear.
//  RULE30_CHK_BITERR_EN undefined: bit_err_count is tied to 0 and no popcount
//    logic is built.
// TESTING
//  1. Reset, then valid seed 0x00000001 followed by correct successors
//     (0x80000003, ...) -> locked=1 the cycle after the 5th word; err_count=0.
//  2. Locked, one successor with bit 0 flipped -> err_pulse for 1 cycle,
//     err_count=1, locked stays 1, the next correct word matches (flywheel),
//     bit_err_count=1 with the macro and 0 without it.
//  3. Locked, 3 consecutive random words -> err_count=3, locked=0 after the 3rd;
//     then 5 correct words from a new seed -> locked=1 again, err_count still 3.
//  4. Stream of 0x00000000 words, valid every cycle -> locked never rises,
//     err_count=0.
//  5. Valid gaps of 1-4 cycles between correct words -> lock timing counted in
//     words, not cycles. clear asserted together with data_valid -> state IDLE,
//     counters 0, that word ignored.
//  6. reset_n pulled low mid-LOCK, asynchronously to clk -> locked, err_pulse and
//     counters read 0 immediately, and the block re-acquires normally after release.

Source files
------------

// File: rtl/rule30_stream_checker_if.sv
// Word stream carried from a Rule 30 PRNG source into the checker.
interface rule30_stream_checker_if #(
    parameter int unsigned N = 32
) ();
    logic [N-1:0] data_in;
    logic         data_valid;

    modport master (
        output data_in,
        output data_valid
    );

    modport slave (
        input data_in,
        input data_valid
    );
endinterface

// File: rtl/rule30_stream_checker.sv
// Rule 30 stream checker: locks onto a PRNG word stream, counts word errors while locked.
// Optional macro RULE30_CHK_BITERR_EN adds a saturating mismatching-bit counter.
module rule30_stream_checker #(
    parameter int unsigned N        = 32,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CW       = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    rule30_stream_checker_if.slave  stream,
    input  logic                    clear,
    output logic                    locked,
    output logic                    err_pulse,
    output logic [CW-1:0]           err_count,
    output logic [CW-1:0]           bit_err_count
);
    localparam int unsigned RW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MW = $clog2(LOSS_CNT + 1);

    localparam logic [RW-1:0] RUN_LAST  = RW'(LOCK_CNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_CNT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACQ  = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  ref_q, ref_d;
    logic [RW-1:0] run_q, run_d;
    logic [MW-1:0] miss_q, miss_d;
    logic          err_pulse_q, err_pulse_d;
    logic [CW-1:0] err_count_q, err_count_d;

    logic [N-1:0]  pred;
    logic          match;
    logic          lock_miss;

    for (genvar i = 0; i < N; i++) begin : g_pred
        assign pred[i] = ref_q[(i + 1) % N] ^ (ref_q[i] | ref_q[(i + N - 1) % N]);
    end

    // Zero is a Rule 30 fixed point, so an all-zero word can never prove sync.
    assign match     = (stream.data_in == pred) && (|stream.data_in);
    assign lock_miss = stream.data_valid && !clear && (state_q == ST_LOCK) && !match;

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        run_d       = run_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        if (clear) begin
            state_d     = ST_IDLE;
            run_d       = '0;
            miss_d      = '0;
            err_count_d = '0;
        end else if (stream.data_valid) begin
            case (state_q)
                ST_IDLE: begin
                    ref_d   = stream.data_in;
                    run_d   = '0;
                    state_d = ST_ACQ;
                end
                ST_ACQ: begin
                    ref_d = stream.data_in;
                    if (match) begin
                        if (run_q == RUN_LAST) begin
                            state_d = ST_LOCK;
                            miss_d  = '0;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                ST_LOCK: begin
                    if (match) begin
                        ref_d  = stream.data_in;
                        miss_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (miss_q == MISS_LAST) begin
                            state_d = ST_ACQ;
                            ref_d   = stream.data_in;
                            run_d   = '0;
                            miss_d  = '0;
                        end else begin
                            // Flywheel: keep following the predicted sequence.
                            miss_d = miss_q + 1'b1;
                            ref_d  = pred;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ref_q       <= '0;
            run_q       <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = (state_q == ST_LOCK);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

`ifdef RULE30_CHK_BITERR_EN
    localparam int unsigned PW = $clog2(N + 1);

    logic [N-1:0]  diff;
    logic [PW-1:0] pop;
    logic [CW:0]   bit_sum;
    logic [CW-1:0] bit_err_q;

    assign diff = stream.data_in ^ pred;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + PW'(diff[i]);
        end
    end

    assign bit_sum = {1'b0, bit_err_q} + (CW + 1)'(pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_err_q <= '0;
        end else if (clear) begin
            bit_err_q <= '0;
        end else if (lock_miss) begin
            bit_err_q <= bit_sum[CW] ? '1 : bit_sum[CW-1:0];
        end
    end

    assign bit_err_count = bit_err_q;
`else
    assign bit_err_count = '0;
`endif
endmodule

// File: tb/tb_rule30_stream_checker.sv
// Directed table-driven bench for rule30_stream_checker, plus saturation and async-reset sequences.
module tb_rule30_stream_checker;
    localparam int unsigned N    = 32;
    localparam int unsigned CW   = 4;
    localparam int          MAXC = 15;

    logic          clk;
    logic          reset_n;
    logic          clear;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;
    logic [CW-1:0] bit_err_count;

    rule30_stream_checker_if #(.N(N)) sif ();

    rule30_stream_checker #(
        .N        (N),
        .LOCK_CNT (4),
        .LOSS_CNT (3),
        .CW       (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stream        (sif),
        .clear         (clear),
        .locked        (locked),
        .err_pulse     (err_pulse),
        .err_count     (err_count),
        .bit_err_count (bit_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        vld;
        logic [31:0] data;
        logic        lk;
        logic        pl;
        int          ec;
        int          bc;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] nxt(input logic [31:0] r);
        logic [31:0] e;
        for (int i = 0; i < 32; i++) begin
            e[i] = r[(i + 1) % 32] ^ (r[i] | r[(i + 31) % 32]);
        end
        return e;
    endfunction

    function automatic int sat(input int x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    function automatic int pop_err(input logic [31:0] a, input logic [31:0] b);
`ifdef RULE30_CHK_BITERR_EN
        return $countones(a ^ b);
`else
        return (a == b) ? 0 : 0;
`endif
    endfunction

    task automatic add(input logic c, input logic v, input logic [31:0] d,
                       input logic l, input logic p, input int e, input int b);
        vec_t t;
        t.clr = c; t.vld = v; t.data = d; t.lk = l; t.pl = p; t.ec = e; t.bc = b;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic v, input logic [31:0] d);
        clear          = c;
        sif.data_valid = v;
        sif.data_in    = d;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] w[0:15];
    logic [31:0] t[0:4];
    logic [31:0] u[0:4];
    logic [31:0] cur;
    logic [31:0] bw;
    int          bm;

    initial begin
        w[0] = 32'h0000_0001;
        t[0] = 32'h0000_0100;
        u[0] = 32'h0001_0000;
        for (int k = 1; k < 16; k++) w[k] = nxt(w[k-1]);
        for (int k = 1; k < 5; k++) begin
            t[k] = nxt(t[k-1]);
            u[k] = nxt(u[k-1]);
        end

        // Seed 1 plus four successors: lock after the 5th word.
        for (int k = 0; k < 5; k++) add(0, 1, w[k], (k == 4), 0, 0, 0);
        // One bit-0 flip in LOCK, then flywheel match, a gap, another match.
        bm = pop_err(w[5] ^ 32'h1, w[5]);
        add(0, 1, w[5] ^ 32'h1, 1, 1, 1, bm);
        add(0, 1, w[6], 1, 0, 1, bm);
        add(0, 0, 32'h0, 1, 0, 1, bm);
        add(0, 1, w[7], 1, 0, 1, bm);
        // clear with a valid word: word ignored, counters zero, back to IDLE.
        bm = 0;
        add(1, 1, w[8], 0, 0, 0, 0);
        for (int k = 8; k < 13; k++) add(0, 1, w[k], (k == 12), 0, 0, 0);
        // Three random words in LOCK drop lock on the third.
        bm = sat(bm + pop_err(32'h1234_5678, w[13]));
        add(0, 1, 32'h1234_5678, 1, 1, 1, bm);
        bm = sat(bm + pop_err(32'hdead_beef, w[14]));
        add(0, 1, 32'hdead_beef, 1, 1, 2, bm);
        bm = sat(bm + pop_err(32'h0bad_f00d, w[15]));
        add(0, 1, 32'h0bad_f00d, 0, 1, 3, bm);
        // New seed re-locks after 5 words; error count retained.
        for (int k = 0; k < 5; k++) add(0, 1, t[k], (k == 4), 0, 3, bm);
        // Clear, then all-zero words every cycle never lock.
        add(1, 0, 32'h0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) add(0, 1, 32'h0, 0, 0, 0, 0);
        // Correct words with gaps of 1..4 idle cycles: lock after the 5th word.
        for (int k = 0; k < 5; k++) begin
            add(0, 1, u[k], (k == 4), 0, 0, 0);
            if (k < 4) for (int g = 0; g <= k; g++) add(0, 0, 32'h0, 0, 0, 0, 0);
        end

        clear          = 1'b0;
        sif.data_valid = 1'b0;
        sif.data_in    = '0;
        reset_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset locked", 32'(locked), 32'd0);
        chk("reset err_pulse", 32'(err_pulse), 32'd0);
        chk("reset err_count", 32'(err_count), 32'd0);
        chk("reset bit_err_count", 32'(bit_err_count), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].clr, vecs[i].vld, vecs[i].data);
            chk($sformatf("row%0d locked", i), 32'(locked), 32'(vecs[i].lk));
            chk($sformatf("row%0d err_pulse", i), 32'(err_pulse), 32'(vecs[i].pl));
            chk($sformatf("row%0d err_count", i), 32'(err_count), 32'(vecs[i].ec));
            chk($sformatf("row%0d bit_err_count", i), 32'(bit_err_count), 32'(vecs[i].bc));
        end

        // Alternating miss/match pairs stay locked and saturate both counters.
        cur = u[4];
        for (int k = 0; k < 17; k++) begin
            bw = nxt(cur) ^ 32'h1;
            step(0, 1, bw);
            chk($sformatf("sat%0d err_pulse", k), 32'(err_pulse), 32'd1);
            chk($sformatf("sat%0d locked", k), 32'(locked), 32'd1);
            chk($sformatf("sat%0d err_count", k), 32'(err_count), 32'(sat(k + 1)));
            chk($sformatf("sat%0d bit_err_count", k), 32'(bit_err_count),
                32'(sat(pop_err(bw, nxt(cur)) * (k + 1))));
            cur = nxt(cur);
            cur = nxt(cur);
            step(0, 1, cur);
            chk($sformatf("sat%0d pulse_clear", k), 32'(err_pulse), 32'd0);
        end

        // Asynchronous reset mid-cycle while locked with a pending error pulse.
        bw = nxt(cur) ^ 32'h1;
        clear          = 1'b0;
        sif.data_valid = 1'b1;
        sif.data_in    = bw;
        @(posedge clk);
        #2;
        sif.data_valid = 1'b0;
        reset_n        = 1'b0;
        #1;
        chk("areset locked", 32'(locked), 32'd0);
        chk("areset err_pulse", 32'(err_pulse), 32'd0);
        chk("areset err_count", 32'(err_count), 32'd0);
        chk("areset bit_err_count", 32'(bit_err_count), 32'd0);
        #3;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(0, 1, w[k]);
            chk($sformatf("relock%0d locked", k), 32'(locked), 32'(k == 4));
            chk($sformatf("relock%0d err_count", k), 32'(err_count), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
